// File: rtl/kronos_mem_arbiter.sv
// Arbitrates the Kronos fetch and load/store ports onto one single-ported memory bus.
// Define KRONOS_ARB_RR_EN for round-robin tie-breaking; otherwise data wins every tie.
module kronos_mem_arbiter (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        wen_q, wen_d;
  logic        win_instr;
  logic        win_data;

`ifdef KRONOS_ARB_RR_EN
  // Set when the data port owned the bus last; reset favours fetch on the first tie.
  logic last_data_q, last_data_d;

  assign win_instr = instr_req & (~data_req | last_data_q);

  always_comb begin
    last_data_d = last_data_q;
    if ((state_q == ST_IDLE) && (instr_req | data_req)) begin
      last_data_d = ~win_instr;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  assign win_instr = instr_req & ~data_req;
`endif

  assign win_data = data_req & ~win_instr;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    wen_d   = wen_q;
    case (state_q)
      ST_IDLE: begin
        if (win_instr) begin
          state_d = ST_BUSY_I;
          addr_d  = instr_addr;
          wdata_d = 32'h0;
          mask_d  = 4'h0;
          wen_d   = 1'b0;
        end else if (win_data) begin
          state_d = ST_BUSY_D;
          addr_d  = data_addr;
          wdata_d = data_wr_data;
          mask_d  = data_wr_mask;
          wen_d   = data_wr_en;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // Ownership is locked until the memory completes; always bubble through IDLE.
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mask_q  <= 4'h0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      wen_q   <= wen_d;
    end
  end

  assign mem_req      = (state_q != ST_IDLE);
  assign mem_addr     = addr_q;
  assign mem_wr_data  = wdata_q;
  assign mem_wr_mask  = mask_q;
  assign mem_wr_en    = wen_q;
  assign instr_gnt    = (state_q == ST_BUSY_I) & mem_ack;
  assign data_ack     = (state_q == ST_BUSY_D) & mem_ack;
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;

endmodule

// File: doc/kronos_mem_arbiter.md
# kronos_mem_arbiter

- Shares one single-ported memory bus between the instruction-fetch port and the load/store data port of the Kronos core.
- Arbitrates between the two, latches the winning request into registers, and drives it on the memory bus until the memory acknowledges.
- Returns the acknowledge and read data to the owning requester only.
- Sits between the core's IF/LSU stages and the shared memory.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: core clock.
- `rstz` in 1: asynchronous, active-low reset.
- `instr_addr` in 32: fetch address. Stable while `instr_req` is high and not granted.
- `instr_req` in 1: fetch request.
- `instr_gnt` out 1: fetch complete. `instr_data` is valid in the same cycle.
- `instr_data` out 32: fetch read data.
- `data_addr` in 32: load/store address.
- `data_wr_data` in 32: store data.
- `data_wr_mask` in 4: store byte enables.
- `data_wr_en` in 1: 1 = store, 0 = load.
- `data_req` in 1: load/store request. All `data_*` inputs are stable while it is high and not acked.
- `data_ack` out 1: load/store complete. `data_rd_data` is valid in the same cycle.
- `data_rd_data` out 32: load read data.
- `mem_addr` out 32: memory address (registered).
- `mem_wr_data` out 32: memory write data (registered).
- `mem_wr_mask` out 4: memory byte enables (registered).
- `mem_wr_en` out 1: memory write strobe (registered).
- `mem_req` out 1: memory request.
- `mem_ack` in 1: memory completion. `mem_rd_data` is valid in the same cycle.
- `mem_rd_data` in 32: memory read data.

## Operation
States:
- IDLE: no transfer in flight.
- BUSY_I: instruction transfer in flight.
- BUSY_D: data transfer in flight.

IDLE:
- If neither request is high, stay in IDLE.
- Otherwise pick a winner (see Configuration), latch its fields into the `mem_*` registers, and go to BUSY_I or BUSY_D.
- On an instruction grant: `mem_addr` = `instr_addr`, `mem_wr_en` = 0, `mem_wr_mask` = 0, `mem_wr_data` = 0.
- On a data grant: all four `data_*` fields are latched as presented.

BUSY_x:
- `mem_req` = 1 and the `mem_*` registers hold their values.
- When `mem_ack` = 1: pulse `instr_gnt` (BUSY_I) or `data_ack` (BUSY_D) combinationally in the same cycle, then return to IDLE.

Outputs:
- `mem_req` = (state != IDLE).
- `instr_gnt` = (state == BUSY_I) & `mem_ack`.
- `data_ack` = (state == BUSY_D) & `mem_ack`.
- `instr_data` and `data_rd_data` both pass `mem_rd_data` through combinationally. Each is meaningful only in its own ack cycle.

Ownership rules:
- Once a state is entered, ownership does not change until `mem_ack`. The other request waits.
- Requests are never dropped or reordered.
- A requester must not deassert its request before it receives its ack.

Reset values:
- state = IDLE.
- `mem_req`, `mem_wr_en`, `instr_gnt`, `data_ack` = 0.
- `mem_addr`, `mem_wr_data`, `mem_rd_data` paths = 0; `mem_wr_mask` = 0.
- Round-robin pointer = "last = DATA".

Reset mid-transfer:
- Asserting `rstz` low during a transfer drops `mem_req` immediately (asynchronously).
- Any `mem_ack` that arrives afterwards is ignored.

## Timing
- Request-to-memory latency: a request seen in IDLE at cycle N drives `mem_req` at cycle N+1.
- Minimum transfer: 2 cycles (IDLE, BUSY_x with `mem_ack` in the same cycle). Peak throughput is one transfer per 2 cycles.
- Every return to IDLE is followed by 1 mandatory bubble cycle, including after back-to-back transfers from the same requester.
- Memory wait states extend BUSY_x indefinitely. The `mem_*` registers stay constant for the whole time.
- `mem_ack` seen while in IDLE is ignored.
- Both requests rising in the same IDLE cycle are resolved by the arbitration policy. The loser is granted on the next IDLE cycle provided it is still requesting, which it must be.

## Configuration
Macro `KRONOS_ARB_RR_EN`.

Defined (round-robin):
- A 1-bit pointer records the last owner and is updated on each grant.
- On a tie, the requester that was not the last owner wins.
- Reset pointer = DATA, so the first tie goes to instruction.

Undefined (fixed priority):
- Data always wins a tie.
- No pointer flop exists.
- Instruction fetch can starve under continuous data traffic. This is acceptable because the LSU is a blocking unit.

## Test plan
1. **Reset state:** hold `rstz` low with `instr_req` = `data_req` = 1 → `mem_req` = 0, `instr_gnt` = 0, `data_ack` = 0. Release reset → `mem_req` = 1 one cycle later.
2. **Single fetch:** `instr_req` = 1, `instr_addr` = 0x100, memory acks 2 cycles after `mem_req` with rd_data 0x00000013 → `mem_addr` = 0x100, `mem_wr_en` = 0; `instr_gnt` is a single-cycle pulse with `instr_data` = 0x00000013; `data_ack` stays 0.
3. **Store:** `data_req` = 1, addr 0x2004, wr_data 0xDEADBEEF, mask 0b0011, wr_en 1, zero-wait memory → `mem_*` fields match exactly; `data_ack` is asserted 1 cycle after `data_req`.
4. **Tie:** both requests high from reset, each transfer acked immediately.
   - With `KRONOS_ARB_RR_EN`: grant order I, D, I, D.
   - Without it: grant order D, D, D, … while `data_req` stays high.
5. **Lock during wait states:** instruction owns the bus and `mem_ack` is held low for 5 cycles while `data_req` rises → `mem_addr` is unchanged all 5 cycles; data is granted only in the IDLE cycle after `instr_gnt`.
6. **Reset mid-transfer:** assert `rstz` low in BUSY_D before the ack, then deliver `mem_ack` after release → `data_ack` is never asserted; the state machine restarts from IDLE.
